// File: rtl/tx_arb.sv
// Two-port round-robin frame arbiter for the MAC transmit FIFO.
// Pads short frames and appends terminator words.
module tx_arb #(
  parameter int MIN_LEN    = 60,
  parameter int TERM_WORDS = 1
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       in0_valid,
  input  logic [7:0] in0_data,
  input  logic       in0_last,
  output logic       in0_ready,
  input  logic       in1_valid,
  input  logic [7:0] in1_data,
  input  logic       in1_last,
  output logic       in1_ready,
  input  logic       fifo_full,
  output logic       wr_en,
  output logic [8:0] wr_data,
  output logic [1:0] grant,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    PASS,
    PAD,
    TERM
  } state_t;

  localparam logic [11:0] MIN_L  = 12'(MIN_LEN);
  localparam logic [3:0]  T_LAST = 4'(TERM_WORDS - 1);

  state_t      state, state_n;
  logic        owner, owner_n;
  logic        rr_next, rr_n;
  logic [10:0] len, len_n;
  logic [3:0]  tcnt, tcnt_n;

  logic        sel_valid;
  logic        sel_last;
  logic [7:0]  sel_data;
  logic [11:0] len_p1;

  assign sel_valid = owner ? in1_valid : in0_valid;
  assign sel_last  = owner ? in1_last  : in0_last;
  assign sel_data  = owner ? in1_data  : in0_data;
  assign len_p1    = {1'b0, len} + 12'd1;

  assign busy  = (state != IDLE);
  assign grant = busy ? (owner ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state   <= IDLE;
      owner   <= 1'b0;
      rr_next <= 1'b0;
      len     <= '0;
      tcnt    <= '0;
    end else begin
      state   <= state_n;
      owner   <= owner_n;
      rr_next <= rr_n;
      len     <= len_n;
      tcnt    <= tcnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    owner_n   = owner;
    rr_n      = rr_next;
    len_n     = len;
    tcnt_n    = tcnt;
    wr_en     = 1'b0;
    wr_data   = 9'h000;
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    unique case (state)
      IDLE: begin
        if (in0_valid || in1_valid) begin
          owner_n = (in0_valid && in1_valid) ? rr_next : in1_valid;
          len_n   = '0;
          state_n = PASS;
        end
      end
      PASS: begin
        in0_ready = ~owner & ~fifo_full;
        in1_ready = owner & ~fifo_full;
        if (sel_valid && !fifo_full) begin
          wr_en   = 1'b1;
          wr_data = {1'b1, sel_data};
          len_n   = (len == 11'h7FF) ? len : len_p1[10:0];
          if (sel_last) begin
            tcnt_n = '0;
            // short frames go through PAD; MIN_LEN=1 never does
            state_n = (len_p1 < MIN_L) ? PAD : TERM;
          end
        end
      end
      PAD: begin
        if (!fifo_full) begin
          wr_en   = 1'b1;
          wr_data = 9'h100;
          len_n   = len_p1[10:0];
          if (len_p1 == MIN_L) begin
            tcnt_n  = '0;
            state_n = TERM;
          end
        end
      end
      TERM: begin
        if (!fifo_full) begin
          wr_en  = 1'b1;
          tcnt_n = tcnt + 4'd1;
          if (tcnt == T_LAST) begin
            rr_n    = ~owner;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tx_arb.sv
// Randomized bench for tx_arb against a frame-level model:
// per-frame word lists, arbitration rule and ready/write rules.
module tb_tx_arb;

  localparam int MIN_LEN    = 60;
  localparam int TERM_WORDS = 1;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       in0_valid = 1'b0, in1_valid = 1'b0;
  logic [7:0] in0_data = '0, in1_data = '0;
  logic       in0_last = 1'b0, in1_last = 1'b0;
  logic       in0_ready, in1_ready;
  logic       fifo_full = 1'b0;
  logic       wr_en;
  logic [8:0] wr_data;
  logic [1:0] grant;
  logic       busy;

  tx_arb #(.MIN_LEN(MIN_LEN), .TERM_WORDS(TERM_WORDS)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .in0_valid(in0_valid), .in0_data(in0_data),
    .in0_last(in0_last), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data),
    .in1_last(in1_last), .in1_ready(in1_ready),
    .fifo_full(fifo_full), .wr_en(wr_en), .wr_data(wr_data),
    .grant(grant), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  int n_chk = 0, n_pass = 0;

  logic [7:0] dq0[$], dq1[$];
  bit         lq0[$], lq1[$];
  logic [8:0] exp_q[$];
  int         data_left = 0;
  int         vp0 = 100, vp1 = 100, fp = 0;
  logic [1:0] prev_g = 2'b00;
  bit         iv0 = 0, iv1 = 0, rr = 0;
  bit         x0 = 0, x1 = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
  endtask

  task automatic gen(input bit p, input int n, input bit seq);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = seq ? 8'(i) : 8'($urandom);
      if (!p) begin dq0.push_back(b); lq0.push_back(i == n - 1); end
      else    begin dq1.push_back(b); lq1.push_back(i == n - 1); end
    end
  endtask

  // expected FIFO words for the frame at the head of port p
  task automatic start_frame(input bit p);
    int n = 0;
    if (!p) begin
      for (int i = 0; i < dq0.size(); i++) begin
        exp_q.push_back({1'b1, dq0[i]}); n++;
        if (lq0[i]) break;
      end
    end else begin
      for (int i = 0; i < dq1.size(); i++) begin
        exp_q.push_back({1'b1, dq1[i]}); n++;
        if (lq1[i]) break;
      end
    end
    for (int i = n; i < MIN_LEN; i++) exp_q.push_back(9'h100);
    repeat (TERM_WORDS) exp_q.push_back(9'h000);
    data_left = n;
  endtask

  task automatic drive();
    in0_valid = (dq0.size() > 0) && ($urandom_range(99) < vp0);
    in1_valid = (dq1.size() > 0) && ($urandom_range(99) < vp1);
    in0_data  = (dq0.size() > 0) ? dq0[0] : 8'h00;
    in1_data  = (dq1.size() > 0) ? dq1[0] : 8'h00;
    in0_last  = (lq0.size() > 0) ? lq0[0] : 1'b0;
    in1_last  = (lq1.size() > 0) ? lq1[0] : 1'b0;
    fifo_full = ($urandom_range(99) < fp);
  endtask

  task automatic cycle();
    logic [1:0] g, eg, rdy;
    logic       ow_v, ewr;
    logic [8:0] w;
    @(negedge sys_clk);
    x0 = 0; x1 = 0;
    if (!sys_rst) begin
      g = grant;
      if (prev_g == 2'b00) begin
        eg = 2'b00;
        if (iv0 && iv1) eg = rr ? 2'b10 : 2'b01;
        else if (iv0)   eg = 2'b01;
        else if (iv1)   eg = 2'b10;
        chk("grant", 32'(g), 32'(eg));
        if (g != 2'b00) begin
          start_frame(g[1]);
          rr = ~g[1];
        end
      end else if (g != 2'b00) begin
        chk("grant_hold", 32'(g), 32'(prev_g));
      end else begin
        chk("frame_done", exp_q.size(), 0);
      end
      chk("busy", 32'(busy), 32'(g != 2'b00));
      rdy = (g != 2'b00 && data_left > 0 && !fifo_full) ? g : 2'b00;
      chk("ready", 32'({in1_ready, in0_ready}), 32'(rdy));
      ow_v = g[1] ? in1_valid : in0_valid;
      if (g == 2'b00 || exp_q.size() == 0) ewr = 1'b0;
      else if (data_left > 0) ewr = ow_v & ~fifo_full;
      else ewr = ~fifo_full;
      chk("wr_en", 32'(wr_en), 32'(ewr));
      if (wr_en && exp_q.size() > 0) begin
        w = exp_q.pop_front();
        chk("wr_data", 32'(wr_data), 32'(w));
        if (data_left > 0) data_left--;
      end else if (!wr_en) begin
        chk("wr_idle", 32'(wr_data), 0);
      end
      if (g == 2'b00) begin iv0 = in0_valid; iv1 = in1_valid; end
      x0 = in0_valid & in0_ready;
      x1 = in1_valid & in1_ready;
      prev_g = g;
    end
    @(posedge sys_clk);
    #1;
    if (x0 && dq0.size() > 0) begin void'(dq0.pop_front()); void'(lq0.pop_front()); end
    if (x1 && dq1.size() > 0) begin void'(dq1.pop_front()); void'(lq1.pop_front()); end
    drive();
  endtask

  task automatic run_idle(input int max_cyc);
    int c = 0;
    do begin
      cycle();
      c++;
    end while (c < max_cyc &&
               !(dq0.size() == 0 && dq1.size() == 0 &&
                 exp_q.size() == 0 && prev_g == 2'b00));
    if (c >= max_cyc) chk("timeout", 0, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wr_en"}, 32'(wr_en), 0);
    chk({tag, "_wr_data"}, 32'(wr_data), 0);
    chk({tag, "_ready"}, 32'({in1_ready, in0_ready}), 0);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    #1;
    chk_zero("reset");
    repeat (3) @(posedge sys_clk);
    #2 sys_rst = 1'b0;

    // 64-byte sequential frame on port 0, no pad
    gen(0, 64, 1);
    run_idle(500);

    // short frame on port 1, padded to MIN_LEN
    gen(1, 10, 0);
    run_idle(500);

    // owner valid dropped mid-frame while port 1 waits
    gen(0, 40, 0);
    gen(1, 12, 0);
    vp1 = 0;
    repeat (10) cycle();
    vp0 = 0; vp1 = 100;
    repeat (5) cycle();
    vp0 = 100;
    run_idle(1000);

    // pad boundary lengths, both ports contending
    gen(0, 59, 0); gen(1, 60, 0);
    gen(0, 61, 0); gen(1, 1, 0);
    run_idle(2000);

    // randomized traffic with FIFO backpressure
    vp0 = 80; vp1 = 80; fp = 30;
    for (int i = 0; i < 40; i++) begin
      gen(0, $urandom_range(1, 80), 0);
      gen(1, $urandom_range(1, 80), 0);
    end
    run_idle(40000);

    // asynchronous reset in the middle of a frame
    vp0 = 100; vp1 = 100; fp = 0;
    gen(0, 30, 0);
    repeat (10) cycle();
    #2 sys_rst = 1'b1;
    #1 chk_zero("midrst");
    dq0.delete(); lq0.delete(); dq1.delete(); lq1.delete();
    exp_q.delete();
    data_left = 0; prev_g = 2'b00;
    iv0 = 0; iv1 = 0; rr = 0;
    drive();
    @(posedge sys_clk);
    #3 sys_rst = 1'b0;

    gen(1, 8, 0);
    run_idle(500);
    gen(0, 8, 0); gen(1, 8, 0);
    gen(0, 8, 0); gen(1, 8, 0);
    run_idle(1000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tx_arb.md
# tx_arb

Two-port frame arbiter and write-side sequencer for the MAC transmit path. It accepts byte frames from two independent requesters and grants the shared transmit FIFO write port to one requester at a time, using round-robin between frames. It pads short frames to a minimum length and appends terminator words. It produces the 9-bit FIFO word format: bit 8 = 1 for a frame byte, bit 8 = 0 for a terminator/idle word.

## Interface
- MIN_LEN, 60: minimum payload bytes per frame before termination (excludes preamble/SFD/FCS); legal range 1..2047.
- TERM_WORDS, 1: number of bit8=0 terminator words written after each frame; legal range 1..15.
- sys_clk  in  1  single clock; all logic on its rising edge.
- sys_rst  in  1  reset, asynchronous assert, active-high.
- in0_valid  in  1  requester 0 has a byte.
- in0_data  in  8  requester 0 byte.
- in0_last  in  1  marks the final byte of the frame; qualified by in0_valid.
- in0_ready  out  1  requester 0 byte accepted this cycle when valid & ready.
- in1_valid, in1_data, in1_last, in1_ready: same as the requester 0 signals, for requester 1.
- fifo_full  in  1  downstream FIFO cannot accept a word this cycle.
- wr_en  out  1  write strobe to the FIFO.
- wr_data  out  9  FIFO word {marker, byte}.
- grant  out  2  one-hot current owner; 2'b00 when idle.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, PASS, PAD, TERM. Registers: state, owner (1 bit), rr_next (1 bit), len (11 bits), tcnt (4 bits).
- IDLE: if exactly one inX_valid is high, grant that port. If both are high, grant rr_next. Then go to PASS with len=0. If no port is valid, stay in IDLE. No writes occur in IDLE.
- PASS: in_ready[owner] = ~fifo_full. A transfer is valid & ready on the owner port. On a transfer: wr_en=1, wr_data={1'b1, data}, len <= len+1, saturating at 2047.
  - On a transfer with last=1: if len+1 < MIN_LEN, go to PAD; otherwise go to TERM with tcnt=0.
  - If the owner's valid drops mid-frame, stall in PASS: no write, grant held indefinitely.
- PAD: while ~fifo_full, write {1'b1, 8'h00} and increment len. The write that makes len == MIN_LEN also moves to TERM with tcnt=0.
- TERM: while ~fifo_full, write 9'h000 and increment tcnt. The write with tcnt == TERM_WORDS-1 moves to IDLE and sets rr_next = ~owner.
- The non-owner's in_ready is always 0. Both in_ready are 0 outside PASS.
- wr_en, wr_data and in_ready are combinational from state/owner/fifo_full/valid. wr_data = 9'h000 whenever wr_en=0.
- fifo_full high means no write that cycle in any state; the state/len/tcnt values hold.
- Arithmetic: len compares are unsigned 11-bit. MIN_LEN=1 never enters PAD.
- Reset (async, any state): state=IDLE, owner=0, rr_next=0, len=0, tcnt=0. Resulting outputs: wr_en=0, wr_data=0, in0_ready=in1_ready=0, grant=0, busy=0.
- A frame cut by reset is not terminated. The FIFO is reset by the same sys_rst.

## Timing
- Arbitration costs 1 cycle: a request seen in IDLE at edge N gives in_ready high in the cycle after edge N, at the earliest.
- Throughput in PASS is 1 byte/cycle with fifo_full=0.
- Frame overhead = PAD bytes + TERM_WORDS cycles + 1 IDLE cycle. Minimum spacing between back-to-back frames is TERM_WORDS+1 cycles after the last payload/pad write.
- The grant changes only on the TERM→IDLE→PASS path, never mid-frame.
- Round-robin fairness: with both ports continuously valid, grants alternate 0,1,0,1, starting with port 0 after reset.
- fifo_full asserted and deasserted on any cycle: no word is lost or duplicated, and word order is preserved.

## Test plan
- Single frame on port 0, 64 bytes 0x00..0x3F, full=0: 64 writes {1,byte}, then one 9'h000. grant=01 throughout. No pad.
- Short frame on port 1, 10 bytes, MIN_LEN=60: 10 data writes, 50 writes of 9'h100, then one 9'h000. Total 61 wr_en pulses.
- Both ports continuously valid with 4-byte frames, MIN_LEN=4: grant sequence 01,10,01,10. Each frame is 4 data + 1 term. Exactly 1 idle cycle between frames.
- fifo_full toggled pseudo-randomly during PASS/PAD/TERM: the captured FIFO stream is bit-identical to the full=0 run, and in_ready=0 on every full cycle.
- Owner valid dropped for 5 cycles mid-frame while the other port is valid: no writes, grant unchanged, other port's ready stays 0. The frame resumes intact.
- sys_rst pulsed mid-PASS: all outputs go to 0 immediately, without a clock edge. After release, a new frame on port 1 is granted first when port 0 is idle; port 0 wins when both are valid.
